// File: rtl/sensor_ascii_packer.sv
// sensor_ascii_packer
//   Formats one ultrasonic distance or DHT11 measurement as a printable ASCII
//   line and writes it byte-by-byte into the UART TX FIFO, honouring the FIFO
//   full flag so that no byte is lost or duplicated.
//
//   Distance line : "D:ddd" CR LF              (7 bytes)
//   DHT line      : "H:hh.h T:tt.t" CR LF      (15 bytes)
//   With SENSOR_PACK_CKSUM_EN defined, "*XX" (uppercase hex XOR of every byte
//   from the first letter through the last digit) is inserted before CR LF,
//   giving 10 / 18 byte lines.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   start      one-cycle request to emit a line (sampled in IDLE only)
//   sel_dht    0 = distance line, 1 = DHT line (latched with start)
//   distance   distance in cm
//   hum_int    humidity integer part   (saturates at 99)
//   hum_dec    humidity decimal part   (saturates at 9)
//   tmp_int    temperature integer part (saturates at 99)
//   tmp_dec    temperature decimal part (saturates at 9)
//   fifo_full  TX FIFO full; no write is issued while high
//   tx_data    byte presented to the FIFO write data
//   tx_we      FIFO write strobe, one byte per high cycle
//   busy       high from the cycle after an accepted start through DONE
//   done       one-cycle pulse after the last byte is written
module sensor_ascii_packer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sel_dht,
  input  logic [7:0] distance,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] tmp_int,
  input  logic [7:0] tmp_dec,
  input  logic       fifo_full,
  output logic [7:0] tx_data,
  output logic       tx_we,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DONE} state_t;

`ifdef SENSOR_PACK_CKSUM_EN
  localparam logic [4:0] DIST_LAST = 5'd9;
  localparam logic [4:0] DHT_LAST  = 5'd17;
`else
  localparam logic [4:0] DIST_LAST = 5'd6;
  localparam logic [4:0] DHT_LAST  = 5'd14;
`endif

  state_t     state, state_nxt;
  logic       sel_q;
  logic [4:0] idx;
  logic [4:0] last_idx;

  // Digits are held as ready-to-send ASCII characters.
  logic [7:0] c_d2, c_d1, c_d0;
  logic [7:0] c_h1, c_h0, c_hd;
  logic [7:0] c_t1, c_t0, c_td;

  logic [7:0] hi_sat, hd_sat, ti_sat, td_sat;

  assign hi_sat = (hum_int > 8'd99) ? 8'd99 : hum_int;
  assign hd_sat = (hum_dec > 8'd9)  ? 8'd9  : hum_dec;
  assign ti_sat = (tmp_int > 8'd99) ? 8'd99 : tmp_int;
  assign td_sat = (tmp_dec > 8'd9)  ? 8'd9  : tmp_dec;

  assign last_idx = sel_q ? DHT_LAST : DIST_LAST;

`ifdef SENSOR_PACK_CKSUM_EN
  logic [7:0] cksum;
  logic [4:0] pay_len;

  // Only bytes before the '*' contribute; the hex bytes read cksum while it
  // must stay frozen.
  assign pay_len = sel_q ? 5'd13 : 5'd5;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      sel_q <= 1'b0;
      c_d2  <= '0;
      c_d1  <= '0;
      c_d0  <= '0;
      c_h1  <= '0;
      c_h0  <= '0;
      c_hd  <= '0;
      c_t1  <= '0;
      c_t0  <= '0;
      c_td  <= '0;
`ifdef SENSOR_PACK_CKSUM_EN
      cksum <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start) begin
        sel_q <= sel_dht;
        idx   <= '0;
        c_d2  <= 8'h30 + distance / 8'd100;
        c_d1  <= 8'h30 + (distance / 8'd10) % 8'd10;
        c_d0  <= 8'h30 + distance % 8'd10;
        c_h1  <= 8'h30 + hi_sat / 8'd10;
        c_h0  <= 8'h30 + hi_sat % 8'd10;
        c_hd  <= 8'h30 + hd_sat;
        c_t1  <= 8'h30 + ti_sat / 8'd10;
        c_t0  <= 8'h30 + ti_sat % 8'd10;
        c_td  <= 8'h30 + td_sat;
`ifdef SENSOR_PACK_CKSUM_EN
        cksum <= '0;
`endif
      end else if (tx_we) begin
        idx <= idx + 5'd1;
`ifdef SENSOR_PACK_CKSUM_EN
        if (idx < pay_len) cksum <= cksum ^ tx_data;
`endif
      end
    end
  end

  always_comb begin
    state_nxt = state;
    tx_we     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_SEND;
      ST_SEND: begin
        busy  = 1'b1;
        tx_we = !fifo_full;
        if (tx_we && idx == last_idx) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_data = '0;
    if (state == ST_SEND) begin
      if (!sel_q) begin
        case (idx)
          5'd0: tx_data = 8'h44;
          5'd1: tx_data = 8'h3A;
          5'd2: tx_data = c_d2;
          5'd3: tx_data = c_d1;
          5'd4: tx_data = c_d0;
`ifdef SENSOR_PACK_CKSUM_EN
          5'd5: tx_data = 8'h2A;
          5'd6: tx_data = hex_char(cksum[7:4]);
          5'd7: tx_data = hex_char(cksum[3:0]);
          5'd8: tx_data = 8'h0D;
          5'd9: tx_data = 8'h0A;
`else
          5'd5: tx_data = 8'h0D;
          5'd6: tx_data = 8'h0A;
`endif
          default: tx_data = '0;
        endcase
      end else begin
        case (idx)
          5'd0:  tx_data = 8'h48;
          5'd1:  tx_data = 8'h3A;
          5'd2:  tx_data = c_h1;
          5'd3:  tx_data = c_h0;
          5'd4:  tx_data = 8'h2E;
          5'd5:  tx_data = c_hd;
          5'd6:  tx_data = 8'h20;
          5'd7:  tx_data = 8'h54;
          5'd8:  tx_data = 8'h3A;
          5'd9:  tx_data = c_t1;
          5'd10: tx_data = c_t0;
          5'd11: tx_data = 8'h2E;
          5'd12: tx_data = c_td;
`ifdef SENSOR_PACK_CKSUM_EN
          5'd13: tx_data = 8'h2A;
          5'd14: tx_data = hex_char(cksum[7:4]);
          5'd15: tx_data = hex_char(cksum[3:0]);
          5'd16: tx_data = 8'h0D;
          5'd17: tx_data = 8'h0A;
`else
          5'd13: tx_data = 8'h0D;
          5'd14: tx_data = 8'h0A;
`endif
          default: tx_data = '0;
        endcase
      end
    end
  end

endmodule

// File: doc/sensor_ascii_packer.md
# sensor_ascii_packer

Formats one ultrasonic or DHT11 measurement into a printable ASCII line and writes it byte-by-byte into the UART TX FIFO. It sits between the sensor blocks and the TX FIFO write port, replacing each sensor's private data/write-enable pair with one shared, flow-controlled producer. It latches a snapshot on a start pulse, converts values to decimal digits, and honours the FIFO `full` flag without losing or duplicating bytes.

## Interface
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  one-cycle request to emit a line; sampled only in IDLE.
- `sel_dht`  in  1  0 = distance line, 1 = DHT line; latched with `start`.
- `distance`  in  8  distance in cm, 0..255.
- `hum_int`, `hum_dec`  in  8 each  humidity integer and decimal parts.
- `tmp_int`, `tmp_dec`  in  8 each  temperature integer and decimal parts.
- `fifo_full`  in  1  TX FIFO full; no write is issued while high.
- `tx_data`  out  8  byte presented to the FIFO `wdata`.
- `tx_we`  out  1  FIFO write strobe; each high cycle writes exactly one byte.
- `busy`  out  1  high from the cycle after an accepted start through the DONE cycle.
- `done`  out  1  one-cycle pulse after the last byte is written.

## Operation
- States are IDLE, SEND and DONE.
  - IDLE → SEND when `start`=1. On that edge, latch `sel_dht` and all data inputs, convert them to digit registers, and clear `idx` and the checksum.
  - SEND: `tx_we = !fifo_full`. `tx_data = frame[idx]` is combinational from the registered `idx` and digits. `idx` advances only on cycles where `tx_we`=1.
  - SEND → DONE on the edge that writes the last byte. DONE → IDLE unconditionally.
- Distance frame (7 bytes): "D:" + 3 digits + CR LF. Leading zeros are kept, so 7 is sent as "D:007".
- DHT frame (15 bytes): "H:" + 2 digits + "." + 1 digit + " T:" + 2 digits + "." + 1 digit + CR LF.
- Digit rules:
  - Integer parts saturate at 99 before conversion.
  - Decimal parts saturate at 9.
  - Distance needs no saturation (max 255).
  - Digit = `0x30` + value.
- `start` is ignored in SEND and DONE; a start pulse arriving then is not queued.
- Inputs are don't-care outside the `start` cycle.

## Timing
- Reset values: `tx_data`=`0x00`, `tx_we`=0, `busy`=0, `done`=0, state IDLE, `idx`=0.
- With `fifo_full` held low and `start` high in cycle 0:
  - Byte k is written in cycle 1+k.
  - The distance frame's last byte is written in cycle 7; `done` is high in cycle 8; `busy` is high in cycles 1..8.
- `fifo_full` high during SEND: `tx_we`=0 and `idx` holds. Transmission resumes with the same byte the cycle after `full` falls.
- `fifo_full` high on the last byte delays DONE until that byte is written.
- `rst` during SEND or DONE returns to IDLE on the next edge. The partial frame is abandoned and nothing more is written.
- `tx_data` is don't-care whenever `tx_we`=0.

## Configuration
- `SENSOR_PACK_CKSUM_EN` defined:
  - "*" plus two uppercase hex characters are inserted immediately before CR LF.
  - The hex value is the XOR of every byte from the first letter through the last digit.
  - The checksum accumulates on writes.
  - Frame lengths become 10 bytes (distance) and 18 bytes (DHT).
- `SENSOR_PACK_CKSUM_EN` undefined: no checksum logic and the frame lengths given above.

## Test plan
- Distance path: `distance`=123, `sel_dht`=0, `fifo_full`=0, pulse `start`.
  - Expect `44 3A 31 32 33 0D 0A` in cycles 1..7 and `done` in cycle 8.
  - With `SENSOR_PACK_CKSUM_EN`, expect `2A 34 45` ("*4E") before CR LF.
- DHT path: `hum_int`=45, `hum_dec`=0, `tmp_int`=23, `tmp_dec`=5, `sel_dht`=1.
  - Expect the 15 bytes of "H:45.0 T:23.5" + CR LF, in order.
- Saturation:
  - `hum_int`=120, `tmp_dec`=14 → "H:99." and ".9" in the frame.
  - `distance`=255 → "D:255".
  - `distance`=7 → "D:007".
- Back-pressure: distance frame with `fifo_full` high for 3 cycles after byte 2.
  - Expect `tx_we` low for those 3 cycles, then byte 3 ("2") exactly once.
  - Expect 7 writes total and `done` in cycle 11.
- Busy and reset:
  - A second `start` in cycle 3 is ignored: exactly one frame, and `busy` falls after `done`.
  - `rst` in cycle 4 gives `tx_we`=0 from cycle 5.
  - A new `start` after reset produces a complete frame.
